// File: rtl/stopwatch_ctrl.sv
// Stopwatch seconds controller: synchronised start/stop and clear buttons, an
// IDLE/RUN/PAUSE state machine, a one-second prescaler and minute-counter pulses.
module stopwatch_ctrl #(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  output logic [5:0] sec_count,
  output logic       min_en,
  output logic       min_clr,
  output logic       running
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  // [0],[1] synchronise the raw level, [2] is the history flop for edge detection.
  logic [2:0] ss_sh;
  logic [2:0] cl_sh;

  logic ss_ev;
  logic cl_ev;
  logic tick;

  assign ss_ev = ss_sh[1] & ~ss_sh[2];
  assign cl_ev = cl_sh[1] & ~cl_sh[2];
  assign tick  = (state == RUN) && (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_sh <= 3'b000;
      cl_sh <= 3'b000;
    end else begin
      ss_sh <= {ss_sh[1:0], start_stop};
      cl_sh <= {cl_sh[1:0], clear};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      sec_count <= 6'd0;
      min_en    <= 1'b0;
      min_clr   <= 1'b0;
      running   <= 1'b0;
    end else begin
      min_en  <= 1'b0;
      min_clr <= 1'b0;
      if (cl_ev) begin
        // Clear wins over a simultaneous start/stop press.
        state     <= IDLE;
        presc     <= '0;
        sec_count <= 6'd0;
        min_clr   <= 1'b1;
        running   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (ss_ev) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (ss_ev) begin
              // Prescaler freezes here; a coincident tick is dropped and
              // re-fires on the first cycle after resuming.
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              if (sec_count == 6'd59) begin
                sec_count <= 6'd0;
                min_en    <= 1'b1;
              end else begin
                sec_count <= sec_count + 6'd1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (ss_ev) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl at DIV=4: expected output snapshots are
// queued as stimulus is applied and popped one per clock edge.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       start_stop;
  logic       clear;
  logic [5:0] sec_count;
  logic       min_en;
  logic       min_clr;
  logic       running;

  int compared   = 0;
  int mismatched = 0;
  int en_pulses  = 0;

  // Snapshot layout: {running, min_en, min_clr, sec_count[5:0]}
  logic [8:0] exp_q[$];

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .sec_count  (sec_count),
    .min_en     (min_en),
    .min_clr    (min_clr),
    .running    (running)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input bit run, input int sec, input bit en, input bit clr);
    exp_q.push_back({run, en, clr, 6'(sec)});
  endtask

  // Expected trace for n edges of uninterrupted RUN starting from (sec0, prescaler ph0).
  task automatic push_run(input int sec0, input int ph0, input int n);
    for (int j = 1; j <= n; j++) begin
      int ph;
      int total;
      ph    = ph0 + j;
      total = sec0 + ph / DIV;
      push_exp(1'b1, total % 60, (ph % DIV == 0) && (total % 60 == 0) && (ph / DIV > 0), 1'b0);
    end
  endtask

  task automatic push_const(input bit run, input int sec, input int n);
    for (int j = 0; j < n; j++) push_exp(run, sec, 1'b0, 1'b0);
  endtask

  // Advance n edges; sample 1 time unit after each rising edge and compare.
  task automatic run_edges(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      logic [8:0] snap;
      @(posedge clk);
      #1;
      snap = {running, min_en, min_clr, sec_count};
      if (min_en) en_pulses++;
      if (exp_q.size() == 0) begin
        check_val($sformatf("%s_noexp_%0d", tag, j), {23'd0, snap}, 32'hffff_ffff);
      end else begin
        check_val($sformatf("%s_%0d", tag, j), {23'd0, snap}, {23'd0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    int pause_len;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;

    // Reset state
    push_const(1'b0, 0, 3);
    run_edges("reset", 3);
    rst_n = 1'b1;
    push_const(1'b0, 0, 2);
    run_edges("idle", 2);

    // Start: running on the 3rd edge, first second after 4 RUN cycles
    start_stop = 1'b1;
    push_const(1'b0, 0, 2);
    push_exp(1'b1, 0, 1'b0, 1'b0);
    push_run(0, 0, 4);
    run_edges("start", 7);
    start_stop = 1'b0;

    // 240 RUN cycles: full minute, wrap 59->0 with one min_en pulse
    en_pulses = 0;
    push_run(1, 0, 240);
    run_edges("minute", 240);
    check_val("min_en_pulses", en_pulses, 1);

    // Pause with sec=5, prescaler=2
    push_run(1, 0, 16);
    run_edges("to_pause", 16);
    start_stop = 1'b1;
    push_run(1, 16, 2);
    push_const(1'b0, 5, 1);
    run_edges("pause", 3);
    start_stop = 1'b0;
    pause_len = $urandom_range(45, 60);
    push_const(1'b0, 5, pause_len);
    run_edges("paused", pause_len);

    // Resume: tick after exactly 2 RUN cycles
    start_stop = 1'b1;
    push_const(1'b0, 5, 2);
    push_const(1'b1, 5, 2);
    push_exp(1'b1, 6, 1'b0, 1'b0);
    run_edges("resume", 3);
    start_stop = 1'b0;
    run_edges("resume_tick", 2);

    // Clear and start/stop in the same cycle: clear wins
    en_pulses = 0;
    clear      = 1'b1;
    start_stop = 1'b1;
    push_run(6, 0, 2);
    push_exp(1'b0, 0, 1'b0, 1'b1);
    push_const(1'b0, 0, 6);
    run_edges("clear", 9);
    check_val("clear_no_min_en", en_pulses, 0);
    clear      = 1'b0;
    start_stop = 1'b0;
    push_const(1'b0, 0, 4);
    run_edges("after_clear", 4);

    // Reset mid-RUN at sec=37 while the button is held
    en_pulses = 0;
    start_stop = 1'b1;
    push_const(1'b0, 0, 2);
    push_exp(1'b1, 0, 1'b0, 1'b0);
    push_run(0, 0, 149);
    run_edges("to_37", 152);
    rst_n = 1'b0;
    push_const(1'b0, 0, 3);
    run_edges("mid_reset", 3);
    check_val("reset_no_pulses", en_pulses, 0);

    // Held button at reset release: one press 3 edges later, then held 100 cycles
    rst_n = 1'b1;
    push_const(1'b0, 0, 2);
    push_exp(1'b1, 0, 1'b0, 1'b0);
    push_run(0, 0, 100);
    run_edges("held", 103);
    start_stop = 1'b0;

    check_val("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
